if_id_skid_reg: RTL and testbench

//  Parametrised IF/ID pipeline register with ready/valid handshake, a 2-entry skid buffer, and synchronous flush.

---
 rtl/if_id_skid_reg.sv | 151 +++++++++++++++
 tb/tb_if_id_skid_reg.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with ready/valid handshake and a 2-entry skid buffer.
// The main register drives the decode side; the skid register absorbs the one
// extra entry that fetch can push before it sees in_ready drop. in_ready and
// out_valid come straight from flops, so there is no combinational path from
// in_* to out_* or from out_ready to in_ready.
// A flush (branch/jump taken) squashes everything and presents NOP_INS / PC 0.
// Optional feature: define IF_ID_STALL_CNT_EN to get a saturating decode-stall
// counter on stall_cnt; without it stall_cnt is tied to 0.
//
//  state | meaning
//  ------+-----------------------------------------------
//  EMPTY | nothing held, main shows NOP_INS / PC 0
//  ONE   | main holds the entry presented to decode
//  TWO   | main and skid both full, fetch is back-pressured
module if_id_skid_reg #(
    parameter int               INS_W   = 32,
    parameter int               PC_W    = 32,
    parameter logic [INS_W-1:0] NOP_INS = {INS_W{1'b0}},
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] ins_in,
    input  logic [PC_W-1:0]  pc_add4_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] ins_out,
    output logic [PC_W-1:0]  pc_add4_out,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] stall_cnt
);

    // Encoding doubles as the occupancy count driven on level.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic             in_ready_q, in_ready_nxt;
    logic [INS_W-1:0] main_ins_q, main_ins_nxt;
    logic [PC_W-1:0]  main_pc_q, main_pc_nxt;
    logic [INS_W-1:0] skid_ins_q, skid_ins_nxt;
    logic [PC_W-1:0]  skid_pc_q, skid_pc_nxt;
    logic             acc;
    logic             take;

    assign acc  = in_valid & in_ready_q;
    assign take = (state_q != EMPTY) & out_ready;

    // Next-state and datapath selection; flush overrides every transition.
    always_comb begin
        state_nxt    = state_q;
        main_ins_nxt = main_ins_q;
        main_pc_nxt  = main_pc_q;
        skid_ins_nxt = skid_ins_q;
        skid_pc_nxt  = skid_pc_q;

        if (flush) begin
            state_nxt    = EMPTY;
            main_ins_nxt = NOP_INS;
            main_pc_nxt  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_nxt    = ONE;
                        main_ins_nxt = ins_in;
                        main_pc_nxt  = pc_add4_in;
                    end
                end
                ONE: begin
                    if (acc && take) begin
                        main_ins_nxt = ins_in;
                        main_pc_nxt  = pc_add4_in;
                    end else if (acc) begin
                        state_nxt    = TWO;
                        skid_ins_nxt = ins_in;
                        skid_pc_nxt  = pc_add4_in;
                    end else if (take) begin
                        state_nxt    = EMPTY;
                        main_ins_nxt = NOP_INS;
                        main_pc_nxt  = '0;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a take can happen.
                    if (take) begin
                        state_nxt    = ONE;
                        main_ins_nxt = skid_ins_q;
                        main_pc_nxt  = skid_pc_q;
                    end
                end
                default: begin
                    state_nxt    = EMPTY;
                    main_ins_nxt = NOP_INS;
                    main_pc_nxt  = '0;
                end
            endcase
        end

        in_ready_nxt = (state_nxt != TWO);
    end

    // State, ready flop and data registers; rst wins over flush and everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_ins_q <= NOP_INS;
            main_pc_q  <= '0;
            skid_ins_q <= '0;
            skid_pc_q  <= '0;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= in_ready_nxt;
            main_ins_q <= main_ins_nxt;
            main_pc_q  <= main_pc_nxt;
            skid_ins_q <= skid_ins_nxt;
            skid_pc_q  <= skid_pc_nxt;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign level       = state_q;
    assign ins_out     = main_ins_q;
    assign pc_add4_out = main_pc_q;

`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Count decode stalls, saturating at all-ones; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg. A queue model of the buffer holds the
// expected entries: pushed when the model accepts, popped and compared when the
// model takes. Inputs change 1 time unit after posedge; checks run at negedge.
module tb_if_id_skid_reg;

    localparam int INS_W = 32;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [INS_W-1:0] ins_in;
    logic [PC_W-1:0]  pc_add4_in;
    logic             out_valid;
    logic             out_ready;
    logic [INS_W-1:0] ins_out;
    logic [PC_W-1:0]  pc_add4_out;
    logic [1:0]       level;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [INS_W-1:0] q_ins[$];
    logic [PC_W-1:0]  q_pc[$];
    logic [INS_W-1:0] e_ins;
    logic [PC_W-1:0]  e_pc;
    bit               acc_last;

    always #5 clk = ~clk;

    if_id_skid_reg #(
        .INS_W  (INS_W),
        .PC_W   (PC_W),
        .NOP_INS({INS_W{1'b0}}),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ins_in     (ins_in),
        .pc_add4_in (pc_add4_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ins_out    (ins_out),
        .pc_add4_out(pc_add4_out),
        .level      (level),
        .stall_cnt  (stall_cnt)
    );

    // Advance the reference model by one clock edge using the current inputs.
    // Any popped entry is left in e_ins/e_pc for the caller to compare.
    task automatic model_edge(output bit took);
        took     = out_ready && (q_ins.size() > 0) && !flush && !rst;
        acc_last = in_valid && (q_ins.size() < 2) && !flush && !rst;
        if (took) begin
            e_ins = q_ins.pop_front();
            e_pc  = q_pc.pop_front();
        end
        if (flush || rst) begin
            q_ins.delete();
            q_pc.delete();
        end
        if (acc_last) begin
            q_ins.push_back(ins_in);
            q_pc.push_back(pc_add4_in);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        in_valid   = v;
        ins_in     = ins;
        pc_add4_in = ins + 32'h1000;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (ins_out !== 32'h0) begin errors++; $display("FAIL reset_ins_out got %h want 0", ins_out); end
        checks++;
        if (pc_add4_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_add4_out); end
        checks++;
        if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        q_ins.delete();
        q_pc.delete();
    endtask

    task automatic test_streaming();
        bit took;
        int pops = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 32'hA1 + i, 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if (level !== 2'(q_ins.size()) || in_ready !== 1'b1 ||
                out_valid !== (q_ins.size() > 0)) begin
                errors++;
                $display("FAIL stream_state cyc=%0d level=%0d in_ready=%b out_valid=%b want level=%0d in_ready=1",
                         i, level, in_ready, out_valid, q_ins.size());
            end
            if (i >= 1 && i <= 8) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_latency cyc=%0d out_valid=%b want 1", i, out_valid);
                end
            end
            model_edge(took);
            if (took) begin
                pops++;
                checks++;
                if (ins_out !== e_ins || pc_add4_out !== e_pc) begin
                    errors++;
                    $display("FAIL stream_data got %h/%h want %h/%h", ins_out, pc_add4_out, e_ins, e_pc);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (pops != 8) begin errors++; $display("FAIL stream_count got %0d want 8", pops); end
    endtask

    task automatic test_backpressure();
        bit took;
        int idx = 0;
        int pops = 0;
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[idx], 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (level !== 2'(q_ins.size()) || in_ready !== (q_ins.size() < 2)) begin
                errors++;
                $display("FAIL bp_state cyc=%0d level=%0d in_ready=%b want level=%0d", i, level, in_ready, q_ins.size());
            end
            if (q_ins.size() > 0) begin
                checks++;
                if (ins_out !== 32'h11) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d ins_out=%h want 11", i, ins_out);
                end
            end
            model_edge(took);
            if (acc_last) idx++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (level !== 2'd2 || in_ready !== 1'b0 || idx != 2) begin
            errors++;
            $display("FAIL bp_full level=%0d in_ready=%b accepted=%0d want 2/0/2", level, in_ready, idx);
        end
        for (int i = 0; i < 12 && (idx < 3 || q_ins.size() > 0); i++) begin
            drive(idx < 3, vals[idx < 3 ? idx : 2], 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if (level !== 2'(q_ins.size()) || out_valid !== (q_ins.size() > 0)) begin
                errors++;
                $display("FAIL bp_drain_state level=%0d out_valid=%b want level=%0d", level, out_valid, q_ins.size());
            end
            model_edge(took);
            if (acc_last) idx++;
            if (took) begin
                pops++;
                checks++;
                if (ins_out !== e_ins || pc_add4_out !== e_pc) begin
                    errors++;
                    $display("FAIL bp_order got %h/%h want %h/%h", ins_out, pc_add4_out, e_ins, e_pc);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (pops != 3) begin errors++; $display("FAIL bp_count got %0d want 3", pops); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        bit took;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h44 + 32'(i) * 32'h11, 1'b0, 1'b0);
            @(negedge clk);
            model_edge(took);
            @(posedge clk);
            #1;
        end
        checks++;
        if (level !== 2'd2) begin errors++; $display("FAIL flush_fill level=%0d want 2", level); end
        drive(1'b1, 32'h66, 1'b1, 1'b1);
        @(negedge clk);
        model_edge(took);
        @(posedge clk);
        #1;
        checks++;
        if (level !== 2'd0 || out_valid !== 1'b0 || ins_out !== 32'h0 || pc_add4_out !== 32'h0) begin
            errors++;
            $display("FAIL flush_clear level=%0d out_valid=%b ins=%h pc=%h want 0/0/0/0",
                     level, out_valid, ins_out, pc_add4_out);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (level !== 2'(q_ins.size()) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_no_accept level=%0d in_ready=%b want level=%0d in_ready=1", level, in_ready, q_ins.size());
        end
        model_edge(took);
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        bit took;
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        @(negedge clk);
        model_edge(took);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        @(negedge clk);
        model_edge(took);
        checks++;
        if (!took || ins_out !== e_ins) begin
            errors++;
            $display("FAIL simul_take got %h want %h", ins_out, e_ins);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ins_out !== 32'h22 || pc_add4_out !== 32'h1022 || level !== 2'd1) begin
            errors++;
            $display("FAIL simul_replace ins=%h pc=%h level=%0d want 22/1022/1", ins_out, pc_add4_out, level);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        model_edge(took);
        checks++;
        if (!took || ins_out !== e_ins || pc_add4_out !== e_pc) begin
            errors++;
            $display("FAIL simul_drain got %h/%h want %h/%h", ins_out, pc_add4_out, e_ins, e_pc);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_counter();
        bit took;
        logic [CNT_W-1:0] want5;
        logic [CNT_W-1:0] want15;
`ifdef IF_ID_STALL_CNT_EN
        want5  = 4'd5;
        want15 = 4'd15;
`else
        want5  = '0;
        want15 = '0;
`endif
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        model_edge(took);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL cnt_rst0 got %0d want 0", stall_cnt); end
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        @(negedge clk);
        model_edge(took);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== want5) begin errors++; $display("FAIL cnt_5 got %0d want %0d", stall_cnt, want5); end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== want15) begin errors++; $display("FAIL cnt_sat got %0d want %0d", stall_cnt, want15); end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        model_edge(took);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== want15 || level !== 2'd0) begin
            errors++;
            $display("FAIL cnt_flush got %0d level=%0d want %0d level=0", stall_cnt, level, want15);
        end
        rst = 1'b1;
        @(negedge clk);
        model_edge(took);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL cnt_rst got %0d want 0", stall_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
